bit_serial_gate_seq: RTL and testbench

- Sequencer that applies one shared 1-bit logic gate to a WIDTH-bit operand pair, one bit per clock, LSB first.
- Accepts operands and an opcode over a valid/ready handshake, iterates the bit counter, and returns the WIDTH-bit result over a second valid/ready handshake.
- Serves as the controller that time-shares the single-bit gate datapath (AND/OR/XOR/NAND) for word-wide operations.

---
 rtl/bit_serial_gate_seq.sv | 102 ++++++++++
 tb/tb_bit_serial_gate_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_gate_seq.sv
// rtl/bit_serial_gate_seq.sv - bit-serial sequencer time-sharing one 1-bit gate across a WIDTH-bit word
module bit_serial_gate_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             outValid,
  input  logic             outReady,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_out;
  logic             w_bit;
  logic             w_last;

  // Operands shift right each RUN cycle, so the current bit is always at position 0.
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign out    = r_out;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: a result drain always returns to IDLE before a new accept.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (inValid)  w_next = S_RUN;
      S_RUN:   if (w_last)   w_next = S_DONE;
      S_DONE:  if (outReady) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from registered state only.
  always_comb begin
    inReady  = (r_state == S_IDLE);
    outValid = (r_state == S_DONE);
    busy     = (r_state == S_RUN) || (r_state == S_DONE);
  end

  // The shared single-bit gate applied to the current operand bits.
  always_comb begin
    w_bit = 1'b0;
    case (r_op)
      2'd0:    w_bit = r_a[0] & r_b[0];
      2'd1:    w_bit = r_a[0] | r_b[0];
      2'd2:    w_bit = r_a[0] ^ r_b[0];
      default: w_bit = ~(r_a[0] & r_b[0]);
    endcase
  end

  // Datapath: capture on accept, then one result bit per RUN cycle, LSB first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= 2'd0;
      r_out <= '0;
    end else if (r_state == S_IDLE && inValid) begin
      r_a   <= inA;
      r_b   <= inB;
      r_op  <= op;
      r_out <= '0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_cnt == CW'(i)) r_out[i] <= w_bit;
      end
      r_a <= r_a >> 1;
      r_b <= r_b >> 1;
      if (!w_last) r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_bit_serial_gate_seq.sv
// tb/tb_bit_serial_gate_seq.sv - directed and randomized checks of bit_serial_gate_seq against a word-level model
module tb_bit_serial_gate_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [15:0] inA = '0;
  logic [15:0] inB = '0;
  logic [1:0]  op = '0;
  logic [15:0] out;
  logic        outValid;
  logic        outReady = 1'b0;
  logic        busy;

  logic        v1 = 1'b0;
  logic        rdy1;
  logic [0:0]  a1 = '0;
  logic [0:0]  b1 = '0;
  logic [1:0]  op1 = '0;
  logic [0:0]  out1;
  logic        ov1;
  logic        or1 = 1'b0;
  logic        busy1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit_serial_gate_seq #(.WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .inA(inA), .inB(inB), .op(op), .out(out), .outValid(outValid),
    .outReady(outReady), .busy(busy)
  );

  bit_serial_gate_seq #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .inValid(v1), .inReady(rdy1),
    .inA(a1), .inB(b1), .op(op1), .out(out1), .outValid(ov1),
    .outReady(or1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ref_gate(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o);
    case (o)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation on the 16-bit instance; bp>0 holds outReady low for bp cycles in DONE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                        input int bp, input logic [15:0] exp, input string tag);
    int n;
    logic [15:0] held;
    @(negedge clk);
    outReady = (bp == 0);
    inA = a; inB = b; op = o; inValid = 1'b1;
    check({tag, "_inReady_pre"}, 32'(inReady), 32'd1);
    @(posedge clk); #1;
    inValid = 1'b0;
    check({tag, "_inReady_run"}, 32'(inReady), 32'd0);
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    inA = 16'($urandom); inB = 16'($urandom); op = 2'($urandom);
    n = 0;
    while (!outValid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd16);
    check({tag, "_out"}, 32'(out), 32'(exp));
    if (bp > 0) begin
      held = out;
      repeat (bp) begin
        @(posedge clk); #1;
        check({tag, "_bp_valid"}, 32'(outValid), 32'd1);
        check({tag, "_bp_out"}, 32'(out), 32'(held));
        check({tag, "_bp_inReady"}, 32'(inReady), 32'd0);
      end
      outReady = 1'b1;
    end
    @(posedge clk); #1;
    outReady = 1'b0;
    check({tag, "_drained_valid"}, 32'(outValid), 32'd0);
    check({tag, "_drained_inReady"}, 32'(inReady), 32'd1);
    check({tag, "_drained_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [1:0]  ro;
    logic [15:0] qa [2];
    logic [15:0] qb [2];
    logic [1:0]  qo [2];
    int          acc [2];
    logic [15:0] res [2];
    int k, r;

    // Reset state, both instances
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_outValid", 32'(outValid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_inReady", 32'(inReady), 32'd1);
    check("rst_w1_inReady", 32'(rdy1), 32'd1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Directed OR from the test plan
    run_op(16'h00F0, 16'h0F00, 2'd1, 0, 16'h0FF0, "or_basic");

    // All opcodes on fixed operands
    run_op(16'hA5A5, 16'h0FF0, 2'd0, 0, 16'h05A0, "and_a5");
    run_op(16'hA5A5, 16'h0FF0, 2'd1, 0, 16'hAFF5, "or_a5");
    run_op(16'hA5A5, 16'h0FF0, 2'd2, 0, 16'hAA55, "xor_a5");
    run_op(16'hA5A5, 16'h0FF0, 2'd3, 0, 16'hFA5F, "nand_a5");

    // Backpressure for 10 cycles
    run_op(16'h1234, 16'hFF00, 2'd2, 10, 16'hED34, "bp10");

    // Reset asserted mid-RUN at bit 7 of an AND
    @(negedge clk);
    outReady = 1'b0;
    inA = 16'hFFFF; inB = 16'hFFFF; op = 2'd0; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_outValid", 32'(outValid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_inReady", 32'(inReady), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    run_op(16'hFFFF, 16'h0000, 2'd1, 0, 16'hFFFF, "after_rst");

    // Randomized operations against the word-level model
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); ro = 2'($urandom);
      run_op(ra, rb, ro, int'($urandom_range(0, 3)), ref_gate(ra, rb, ro), $sformatf("rnd%0d", i));
    end

    // Back-to-back with inValid held high and outReady high
    for (int i = 0; i < 2; i++) begin
      qa[i] = 16'($urandom); qb[i] = 16'($urandom); qo[i] = 2'($urandom);
    end
    acc[0] = 0; acc[1] = 0; res[0] = '0; res[1] = '0;
    k = 0; r = 0;
    outReady = 1'b1;
    for (int t = 0; t < 100 && r < 2; t++) begin
      @(negedge clk);
      if (outValid && r < 2) begin
        res[r] = out;
        r++;
      end
      if (inReady) begin
        if (k < 2) begin
          inA = qa[k]; inB = qb[k]; op = qo[k]; inValid = 1'b1;
          acc[k] = cyc;
          k++;
        end else begin
          inValid = 1'b0;
        end
      end
    end
    inValid = 1'b0;
    outReady = 1'b0;
    check("b2b_results_seen", 32'(r), 32'd2);
    check("b2b_interval", 32'(acc[1] - acc[0]), 32'd18);
    check("b2b_res0", 32'(res[0]), 32'(ref_gate(qa[0], qb[0], qo[0])));
    check("b2b_res1", 32'(res[1]), 32'(ref_gate(qa[1], qb[1], qo[1])));
    @(negedge clk);

    // WIDTH=1 instance: NAND of 1,1 then AND of 1,1
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; op1 = (j == 0) ? 2'd3 : 2'd0; v1 = 1'b1; or1 = 1'b0;
      @(posedge clk); #1;
      v1 = 1'b0;
      check($sformatf("w1_busy%0d", j), 32'(busy1), 32'd1);
      check($sformatf("w1_notyet%0d", j), 32'(ov1), 32'd0);
      @(posedge clk); #1;
      check($sformatf("w1_valid%0d", j), 32'(ov1), 32'd1);
      check($sformatf("w1_out%0d", j), 32'(out1), (j == 0) ? 32'd0 : 32'd1);
      or1 = 1'b1;
      @(posedge clk); #1;
      or1 = 1'b0;
      check($sformatf("w1_idle%0d", j), 32'(rdy1), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
